// File: rtl/trace_pkg.sv
// Shared state/trigger encodings and trace-entry layout helpers for bus_trace_monitor.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  localparam logic [1:0] TRIG_ANY  = 2'b00;
  localparam logic [1:0] TRIG_RD   = 2'b01;
  localparam logic [1:0] TRIG_WR   = 2'b10;
  localparam logic [1:0] TRIG_DATA = 2'b11;

  // Entry layout, LSB first: data, addr, rd flag, wr flag, stamp.
  function automatic int entry_w(int aw, int dw, int sw);
    return sw + 2 + aw + dw;
  endfunction

  function automatic int addr_lsb(int dw);
    return dw;
  endfunction

  function automatic int rd_bit(int aw, int dw);
    return aw + dw;
  endfunction

  function automatic int wr_bit(int aw, int dw);
    return aw + dw + 1;
  endfunction

  function automatic int stamp_lsb(int aw, int dw);
    return aw + dw + 2;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port and one registered read port.
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 42,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_trace_monitor.sv
// Circular bus-access trace buffer with address/data/type trigger and
// oldest-first readback of the frozen capture.
module bus_trace_monitor
  import trace_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int POST_TRIG = 8,
  parameter int STAMP_W   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   addr_bus,
  input  logic [DATA_W-1:0]                   data_bus,
  input  logic                                mem_read,
  input  logic                                mem_write,
  input  logic                                arm,
  input  logic                                abort,
  input  logic [1:0]                          trig_mode,
  input  logic [ADDR_W-1:0]                   trig_addr,
  input  logic [ADDR_W-1:0]                   trig_mask,
  input  logic [DATA_W-1:0]                   trig_data,
  input  logic                                rd_en,
  input  logic [$clog2(DEPTH)-1:0]            rd_idx,
  output logic                                rd_valid,
  output logic [STAMP_W+2+ADDR_W+DATA_W-1:0]  rd_data,
  output logic                                rd_err,
  output logic                                armed,
  output logic                                triggered,
  output logic                                done,
  output logic [$clog2(DEPTH):0]              entry_count,
  output logic [$clog2(DEPTH)-1:0]            trig_index
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = IDX_W + 1;
  localparam int ENTRY_W = entry_w(ADDR_W, DATA_W, STAMP_W);
  localparam int A_LSB   = addr_lsb(DATA_W);
  localparam int RD_BIT  = rd_bit(ADDR_W, DATA_W);
  localparam int WR_BIT  = wr_bit(ADDR_W, DATA_W);
  localparam int S_LSB   = stamp_lsb(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bus_trace_monitor: DEPTH must be a power of 2 and at least 4");
  end
  if (POST_TRIG < 0 || POST_TRIG >= DEPTH) begin : g_bad_post
    $error("bus_trace_monitor: POST_TRIG must be in 0..DEPTH-1");
  end

  trace_state_e       state_q, state_d;
  logic [STAMP_W-1:0] stamp_q;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
  logic [IDX_W-1:0]   trig_index_q, trig_index_d;
  logic               rd_valid_q, rd_err_q;

  logic               acc, addr_hit, type_hit, trig_hit, capture, rd_ok;
  logic [IDX_W-1:0]   rd_base, rd_addr;
  logic [ENTRY_W-1:0] entry, ram_rdata;

  assign acc      = mem_read | mem_write;
  assign addr_hit = ((addr_bus ^ trig_addr) & trig_mask) == '0;
  assign capture  = acc && (state_q == ARMED || state_q == POST);

  always_comb begin
    type_hit = 1'b0;
    case (trig_mode)
      TRIG_ANY:  type_hit = 1'b1;
      TRIG_RD:   type_hit = mem_read;
      TRIG_WR:   type_hit = mem_write;
      TRIG_DATA: type_hit = (data_bus == trig_data);
      default:   type_hit = 1'b0;
    endcase
  end

  assign trig_hit = acc && addr_hit && type_hit;

  always_comb begin
    entry                      = '0;
    entry[DATA_W-1:0]          = data_bus;
    entry[A_LSB +: ADDR_W]     = addr_bus;
    entry[RD_BIT]              = mem_read;
    entry[WR_BIT]              = mem_write;
    entry[S_LSB +: STAMP_W]    = stamp_q;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    post_cnt_d   = post_cnt_q;
    trig_index_d = trig_index_q;

    if (capture) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (count_q != FULL) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d      = ARMED;
          wr_ptr_d     = '0;
          count_d      = '0;
          trig_index_d = '0;
        end
      end
      ARMED: begin
        if (trig_hit) begin
          if (POST_TRIG == 0) begin
            state_d = DONE;
          end else begin
            state_d    = POST;
            post_cnt_d = CNT_W'(POST_TRIG);
          end
        end
      end
      POST: begin
        if (acc) begin
          post_cnt_d = post_cnt_q - CNT_W'(1);
          if (post_cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The trigger entry sits POST_TRIG slots before the newest one.
    if (state_d == DONE && state_q != DONE) begin
      trig_index_d = IDX_W'(count_d - CNT_W'(POST_TRIG + 1));
    end

    if (abort) begin
      state_d      = IDLE;
      wr_ptr_d     = '0;
      count_d      = '0;
      post_cnt_d   = '0;
      trig_index_d = '0;
    end
  end

  assign rd_ok   = rd_en && (state_q == DONE) && ({1'b0, rd_idx} < count_q);
  assign rd_base = (count_q == FULL) ? wr_ptr_q : '0;
  assign rd_addr = rd_base + rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      stamp_q      <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      post_cnt_q   <= '0;
      trig_index_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stamp_q      <= stamp_q + STAMP_W'(1);
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      post_cnt_q   <= post_cnt_d;
      trig_index_q <= trig_index_d;
      rd_valid_q   <= rd_en & ~abort;
      rd_err_q     <= rd_en & ~abort & ~rd_ok;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (capture & ~abort),
    .waddr_i (wr_ptr_q),
    .wdata_i (entry),
    .re_i    (rd_ok),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign rd_data     = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;
  assign armed       = (state_q == ARMED);
  assign triggered   = (state_q == POST);
  assign done        = (state_q == DONE);
  assign entry_count = count_q;
  assign trig_index  = trig_index_q;

endmodule

// File: tb/tb_bus_trace_monitor.sv
// Bench for bus_trace_monitor: two instances (POST_TRIG 8 and 2) on one bus,
// checked every cycle against a list-based capture model plus directed checks.
module tb_bus_trace_monitor;
  import trace_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SW = 16;
  localparam int DEPTH = 32;
  localparam int IW = 5;
  localparam int EW = SW + 2 + AW + DW;
  localparam int PT_A = 8;
  localparam int PT_B = 2;
  localparam int SLSB = stamp_lsb(AW, DW);
  localparam int WRB = wr_bit(AW, DW);
  localparam int RDB = rd_bit(AW, DW);
  localparam int ALSB = addr_lsb(DW);

  localparam int S_IDLE = 0;
  localparam int S_ARMED = 1;
  localparam int S_POST = 2;
  localparam int S_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, mem_read, mem_write, arm, abort, rd_en;
  logic [AW-1:0] addr_bus, trig_addr, trig_mask;
  logic [DW-1:0] data_bus, trig_data;
  logic [1:0]    trig_mode;
  logic [IW-1:0] rd_idx;

  logic          rd_valid_v [2];
  logic          rd_err_v [2];
  logic          armed_v [2];
  logic          trig_v [2];
  logic          done_v [2];
  logic [EW-1:0] rd_data_v [2];
  logic [IW:0]   cnt_v [2];
  logic [IW-1:0] tidx_v [2];

  bus_trace_monitor #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(PT_A), .STAMP_W(SW)) dut_a (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(data_bus),
    .mem_read(mem_read), .mem_write(mem_write), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_data(trig_data),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_v[0]), .rd_data(rd_data_v[0]),
    .rd_err(rd_err_v[0]), .armed(armed_v[0]), .triggered(trig_v[0]), .done(done_v[0]),
    .entry_count(cnt_v[0]), .trig_index(tidx_v[0])
  );

  bus_trace_monitor #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(PT_B), .STAMP_W(SW)) dut_b (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(data_bus),
    .mem_read(mem_read), .mem_write(mem_write), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_data(trig_data),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_v[1]), .rd_data(rd_data_v[1]),
    .rd_err(rd_err_v[1]), .armed(armed_v[1]), .triggered(trig_v[1]), .done(done_v[1]),
    .entry_count(cnt_v[1]), .trig_index(tidx_v[1])
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: captured entries kept as a plain list, oldest at index 0.
  logic [EW-1:0] m_tr [2][DEPTH];
  int            m_n [2];
  int            m_st [2];
  int            m_left [2];
  int            m_tidx [2];
  logic          m_rv [2];
  logic          m_re [2];
  logic [EW-1:0] m_rd [2];
  logic [SW-1:0] m_stamp;

  function automatic bit m_match();
    bit a_ok;
    bit t_ok;
    a_ok = (((addr_bus ^ trig_addr) & trig_mask) == '0);
    case (trig_mode)
      2'b00:   t_ok = 1'b1;
      2'b01:   t_ok = mem_read;
      2'b10:   t_ok = mem_write;
      default: t_ok = (data_bus == trig_data);
    endcase
    return (mem_read || mem_write) && a_ok && t_ok;
  endfunction

  task automatic m_push(input int k, input logic [EW-1:0] e);
    if (m_n[k] == DEPTH) begin
      for (int i = 0; i < DEPTH - 1; i++) m_tr[k][i] = m_tr[k][i + 1];
      m_tr[k][DEPTH - 1] = e;
    end else begin
      m_tr[k][m_n[k]] = e;
      m_n[k] = m_n[k] + 1;
    end
  endtask

  task automatic model_step();
    logic [EW-1:0] e;
    bit acc;
    bit hit;
    int pt;
    acc = mem_read || mem_write;
    hit = m_match();
    e = {m_stamp, mem_write, mem_read, addr_bus, data_bus};
    for (int k = 0; k < 2; k++) begin
      pt = (k == 0) ? PT_A : PT_B;
      if (reset || abort) begin
        m_rv[k] = 1'b0; m_re[k] = 1'b0; m_rd[k] = '0;
      end else begin
        m_rv[k] = rd_en;
        if (rd_en && m_st[k] == S_DONE && int'(rd_idx) < m_n[k]) begin
          m_re[k] = 1'b0; m_rd[k] = m_tr[k][rd_idx];
        end else begin
          m_re[k] = rd_en; m_rd[k] = '0;
        end
      end
      if (reset || abort) begin
        m_st[k] = S_IDLE; m_n[k] = 0; m_left[k] = 0; m_tidx[k] = 0;
      end else begin
        case (m_st[k])
          S_ARMED: if (acc) begin
            m_push(k, e);
            if (hit) begin
              if (pt == 0) begin m_st[k] = S_DONE; m_tidx[k] = m_n[k] - 1; end
              else begin m_st[k] = S_POST; m_left[k] = pt; end
            end
          end
          S_POST: if (acc) begin
            m_push(k, e);
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin m_st[k] = S_DONE; m_tidx[k] = m_n[k] - 1 - pt; end
          end
          default: if (arm) begin m_st[k] = S_ARMED; m_n[k] = 0; end
        endcase
      end
    end
    m_stamp = reset ? '0 : m_stamp + SW'(1);
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("armed[%0d]", k), 64'(armed_v[k]), 64'(m_st[k] == S_ARMED));
      chk($sformatf("triggered[%0d]", k), 64'(trig_v[k]), 64'(m_st[k] == S_POST));
      chk($sformatf("done[%0d]", k), 64'(done_v[k]), 64'(m_st[k] == S_DONE));
      chk($sformatf("entry_count[%0d]", k), 64'(cnt_v[k]), 64'(m_n[k]));
      if (m_st[k] == S_DONE)
        chk($sformatf("trig_index[%0d]", k), 64'(tidx_v[k]), 64'(m_tidx[k]));
      chk($sformatf("rd_valid[%0d]", k), 64'(rd_valid_v[k]), 64'(m_rv[k]));
      chk($sformatf("rd_err[%0d]", k), 64'(rd_err_v[k]), 64'(m_re[k]));
      chk($sformatf("rd_data[%0d]", k), 64'(rd_data_v[k]), 64'(m_rd[k]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clr();
    reset = 0; arm = 0; abort = 0; rd_en = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic access(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_read = r; mem_write = w; addr_bus = a; data_bus = d;
    tick();
    mem_read = 0; mem_write = 0;
  endtask

  task automatic pulse_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic pulse_abort();
    abort = 1; tick(); abort = 0;
  endtask

  task automatic set_trig(input logic [1:0] m, input logic [AW-1:0] a, input logic [AW-1:0] k, input logic [DW-1:0] d);
    trig_mode = m; trig_addr = a; trig_mask = k; trig_data = d;
  endtask

  task automatic rd_req(input logic [IW-1:0] idx);
    rd_en = 1; rd_idx = idx; tick(); rd_en = 0;
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] taddr;
    logic [AW-1:0] tmask;
    logic [DW-1:0] tdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rd;
    logic          wr;
    logic          exp_trig;
    logic [IW:0]   exp_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [SW-1:0] prev_s;
    logic [SW-1:0] cur_s;
    logic [SW-1:0] diff;

    vecs[0] = '{2'b00, 16'h1234, 16'hFFFF, 8'h00, 16'h1234, 8'h00, 1'b1, 1'b0, 1'b1, 6'd1};
    vecs[1] = '{2'b00, 16'h1234, 16'hFFFF, 8'h00, 16'h1235, 8'h00, 1'b1, 1'b0, 1'b0, 6'd1};
    vecs[2] = '{2'b01, 16'h00F0, 16'h00F0, 8'h00, 16'hABF3, 8'h11, 1'b1, 1'b0, 1'b1, 6'd1};
    vecs[3] = '{2'b01, 16'h00F0, 16'h00F0, 8'h00, 16'hABF3, 8'h11, 1'b0, 1'b1, 1'b0, 6'd1};
    vecs[4] = '{2'b10, 16'h8000, 16'h8000, 8'h00, 16'h9000, 8'h22, 1'b0, 1'b1, 1'b1, 6'd1};
    vecs[5] = '{2'b10, 16'h8000, 16'h8000, 8'h00, 16'h7FFF, 8'h22, 1'b0, 1'b1, 1'b0, 6'd1};
    vecs[6] = '{2'b11, 16'h0200, 16'hFFFF, 8'h55, 16'h0200, 8'h55, 1'b1, 1'b1, 1'b1, 6'd1};
    vecs[7] = '{2'b11, 16'h0200, 16'hFFFF, 8'h55, 16'h0200, 8'h56, 1'b0, 1'b1, 1'b0, 6'd1};
    vecs[8] = '{2'b01, 16'h0300, 16'hFFFF, 8'h00, 16'h0300, 8'h33, 1'b1, 1'b1, 1'b1, 6'd1};
    vecs[9] = '{2'b10, 16'h0000, 16'h0000, 8'h00, 16'h4444, 8'h44, 1'b0, 1'b0, 1'b0, 6'd0};

    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_st[k] = S_IDLE; m_left[k] = 0; m_tidx[k] = 0;
      m_rv[k] = 0; m_re[k] = 0; m_rd[k] = '0;
    end
    m_stamp = '0;
    clr();
    addr_bus = '0; data_bus = '0; rd_idx = '0;
    set_trig(2'b00, 16'h0000, 16'hFFFF, 8'h00);

    // Reset with strobes and arm active, then idle accesses are not captured.
    reset = 1; mem_read = 1; mem_write = 1; arm = 1; addr_bus = 16'h0000;
    repeat (3) tick();
    chk("reset armed", 64'(armed_v[0]), 64'd0);
    chk("reset count", 64'(cnt_v[0]), 64'd0);
    clr();
    for (int i = 0; i < 10; i++) access(1'b1, 1'b0, AW'(i), 8'hA0);
    chk("idle count a", 64'(cnt_v[0]), 64'd0);
    chk("idle count b", 64'(cnt_v[1]), 64'd0);
    $display("reset/idle sequence complete");

    // Trigger-qualifier table.
    foreach (vecs[v]) begin
      pulse_abort();
      set_trig(vecs[v].mode, vecs[v].taddr, vecs[v].tmask, vecs[v].tdata);
      pulse_arm();
      access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].data);
      chk($sformatf("vec%0d trig a", v), 64'(trig_v[0]), 64'(vecs[v].exp_trig));
      chk($sformatf("vec%0d trig b", v), 64'(trig_v[1]), 64'(vecs[v].exp_trig));
      chk($sformatf("vec%0d count", v), 64'(cnt_v[0]), 64'(vecs[v].exp_cnt));
      $display("vector %0d: mode=%0d addr=%h data=%h rd=%0b wr=%0b", v, vecs[v].mode,
               vecs[v].addr, vecs[v].data, vecs[v].rd, vecs[v].wr);
    end

    // Write trigger at 0x0102 with spaced accesses; instance b has POST_TRIG=2.
    pulse_abort();
    set_trig(2'b10, 16'h0102, 16'hFFFF, 8'h00);
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      access(1'b0, 1'b1, 16'h0100 + AW'(i), 8'h10 + DW'(i));
      tick();
      tick();
    end
    chk("t1 done b", 64'(done_v[1]), 64'd1);
    chk("t1 count b", 64'(cnt_v[1]), 64'd5);
    chk("t1 trig_index b", 64'(tidx_v[1]), 64'd2);
    prev_s = '0;
    for (int i = 0; i < 5; i++) begin
      rd_req(IW'(i));
      cur_s = rd_data_v[1][SLSB +: SW];
      chk("t1 addr", 64'(rd_data_v[1][ALSB +: AW]), 64'h0100 + 64'(i));
      chk("t1 data", 64'(rd_data_v[1][DW-1:0]), 64'h10 + 64'(i));
      chk("t1 wr flag", 64'(rd_data_v[1][WRB]), 64'd1);
      chk("t1 rd flag", 64'(rd_data_v[1][RDB]), 64'd0);
      if (i > 0) begin
        diff = cur_s - prev_s;
        chk("t1 stamp spacing", 64'(diff), 64'd3);
      end
      prev_s = cur_s;
      $display("t1 read idx %0d: %h", i, rd_data_v[1]);
    end
    rd_req(IW'(5));
    chk("t1 idx5 err", 64'(rd_err_v[1]), 64'd1);
    chk("t1 idx5 data", 64'(rd_data_v[1]), 64'd0);
    rd_req(IW'(31));
    chk("t1 idx31 err", 64'(rd_err_v[1]), 64'd1);
    chk("t1 idx31 valid", 64'(rd_valid_v[1]), 64'd1);

    // 40 back-to-back reads, read trigger at 0x001F, buffer wraps.
    pulse_abort();
    set_trig(2'b01, 16'h001F, 16'hFFFF, 8'h00);
    pulse_arm();
    rd_req(IW'(0));
    chk("t2 read while armed err", 64'(rd_err_v[0]), 64'd1);
    chk("t2 read while armed data", 64'(rd_data_v[0]), 64'd0);
    for (int i = 0; i < 40; i++) access(1'b1, 1'b0, AW'(i), DW'($urandom_range(0, 255)));
    chk("t2 done a", 64'(done_v[0]), 64'd1);
    chk("t2 count a", 64'(cnt_v[0]), 64'd32);
    chk("t2 trig_index a", 64'(tidx_v[0]), 64'd23);
    chk("t2 trig_index b", 64'(tidx_v[1]), 64'd29);
    rd_en = 1;
    for (int i = 0; i < 32; i++) begin
      rd_idx = IW'(i);
      tick();
      chk("t2 addr a", 64'(rd_data_v[0][ALSB +: AW]), 64'(8 + i));
      chk("t2 addr b", 64'(rd_data_v[1][ALSB +: AW]), 64'(2 + i));
    end
    rd_en = 0;
    $display("t2 wrap readback complete");

    // Data-match trigger, then zero mask with any-access mode.
    pulse_abort();
    set_trig(2'b11, 16'h0200, 16'hFFFF, 8'h55);
    pulse_arm();
    access(1'b0, 1'b1, 16'h0200, 8'h54);
    chk("t3 no match on 0x54", 64'(armed_v[0]), 64'd1);
    access(1'b0, 1'b1, 16'h0200, 8'h55);
    chk("t3 match on 0x55", 64'(trig_v[0]), 64'd1);
    pulse_abort();
    set_trig(2'b00, 16'h1234, 16'h0000, 8'h00);
    pulse_arm();
    access(1'b1, 1'b0, AW'($urandom_range(0, 65535)), 8'h00);
    chk("t3 zero mask trig", 64'(trig_v[0]), 64'd1);
    $display("t3 data/zero-mask triggers complete");

    // Abort in POST with three accesses left; arm+abort together.
    pulse_abort();
    pulse_arm();
    for (int i = 0; i < 6; i++) access(1'b1, 1'b0, AW'(i), 8'h00);
    chk("t4 in post", 64'(trig_v[0]), 64'd1);
    pulse_abort();
    chk("t4 abort state", 64'(trig_v[0]), 64'd0);
    chk("t4 abort count", 64'(cnt_v[0]), 64'd0);
    arm = 1; abort = 1; tick(); clr();
    chk("t4 arm+abort idle", 64'(armed_v[0]), 64'd0);
    $display("t4 abort sequence complete");

    // Reset mid-POST with a matching access; stamp restarts from zero.
    pulse_arm();
    access(1'b1, 1'b0, 16'h0001, 8'h00);
    access(1'b1, 1'b0, 16'h0002, 8'h00);
    reset = 1; mem_read = 1; addr_bus = 16'h0003;
    tick();
    clr();
    chk("t5 reset triggered", 64'(trig_v[0]), 64'd0);
    chk("t5 reset armed", 64'(armed_v[0]), 64'd0);
    chk("t5 reset count", 64'(cnt_v[0]), 64'd0);
    pulse_arm();
    for (int i = 0; i < 9; i++) access(1'b1, 1'b0, AW'(i), 8'h00);
    chk("t5 done a", 64'(done_v[0]), 64'd1);
    rd_req(IW'(0));
    chk("t5 first stamp a", 64'(rd_data_v[0][SLSB +: SW]), 64'd1);
    chk("t5 first stamp b", 64'(rd_data_v[1][SLSB +: SW]), 64'd1);
    $display("t5 reset-in-post complete");

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        int msel;
        msel = $urandom_range(0, 3);
        set_trig(2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)),
                 (msel == 0) ? 16'h0000 : (msel == 1) ? 16'h0003 : (msel == 2) ? 16'h000F : 16'hFFFF,
                 DW'($urandom_range(0, 3)));
      end
      reset = ($urandom_range(0, 299) == 0);
      arm = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 59) == 0);
      mem_read = ($urandom_range(0, 1) == 1);
      mem_write = ($urandom_range(0, 2) == 0);
      addr_bus = AW'($urandom_range(0, 15));
      data_bus = DW'($urandom_range(0, 3));
      rd_en = ($urandom_range(0, 2) == 0);
      rd_idx = IW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    clr();
    $display("random traffic complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
